keypad_scanner: RTL and testbench

//   Input-side counterpart of the time-multiplexed 7-segment driver. Scans a 4x4 active-low key

---
 rtl/keypad_scanner_pkg.sv | 27 ++
 rtl/keypad_scanner_tick_gen.sv | 33 +++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner_pkg: shared defaults, FSM encodings, column picker  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package keypad_scanner_pkg;

    localparam int KEY_SCAN_DIV   = 100000;
    localparam int KEY_DEBOUNCE_N = 20;

    localparam logic [1:0] KS_IDLE     = 2'd0;
    localparam logic [1:0] KS_SCAN     = 2'd1;
    localparam logic [1:0] KS_DEBOUNCE = 2'd2;
    localparam logic [1:0] KS_PRESSED  = 2'd3;

    // Lowest-index active-low column; only meaningful when col != 4'hF.
    function automatic logic [1:0] pick_col(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col[c]) idx = 2'(c);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen: one-clk strobe every DIV clocks                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_gen
    import keypad_scanner_pkg::*;
#(
    parameter int DIV = KEY_SCAN_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(DIV - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? 32'd0 : cnt_q + 32'd1;
    end

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'd0;
        else        cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner: 4x4 active-low matrix scan with press/release      |
// | debounce and one key_valid pulse per accepted press. Rev 1.0       |
// +--------------------------------------------------------------------+
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV   = KEY_SCAN_DIV,
    parameter int DEBOUNCE_N = KEY_DEBOUNCE_N
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int             DW         = $clog2(DEBOUNCE_N + 1);
    localparam logic [DW-1:0]  DEB_TARGET = DW'(DEBOUNCE_N);
    localparam logic [DW-1:0]  DEB_ONE    = DW'(1);

    logic [3:0]    col_meta_q, col_s_q;
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [DW-1:0] rel_q, rel_d;
    logic [3:0]    row_out_q, row_out_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          key_any;
    logic [1:0]    col_pick;
    logic [DW-1:0] deb_inc, rel_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_s_q    <= col_meta_q;
        end
    end

    tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign key_any  = (col_s_q != 4'hF);
    assign col_pick = pick_col(col_s_q);
    // Counters stop at the target so they can never wrap back to a small value.
    assign deb_inc  = (deb_q == DEB_TARGET) ? deb_q : deb_q + DEB_ONE;
    assign rel_inc  = (rel_q == DEB_TARGET) ? rel_q : rel_q + DEB_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= KS_IDLE;
            row_q       <= 2'd0;
            cand_q      <= 4'd0;
            deb_q       <= '0;
            rel_q       <= '0;
            row_out_q   <= 4'b0000;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cand_q      <= cand_d;
            deb_q       <= deb_d;
            rel_q       <= rel_d;
            row_out_q   <= row_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        rel_d   = rel_q;
        if (tick) begin
            case (state_q)
                KS_IDLE: begin
                    if (key_any) begin
                        row_d   = 2'd0;
                        state_d = KS_SCAN;
                    end
                end
                KS_SCAN: begin
                    if (key_any) begin
                        cand_d  = {row_q, col_pick};
                        deb_d   = DEB_ONE;
                        state_d = KS_DEBOUNCE;
                    end else if (row_q == 2'd3) begin
                        state_d = KS_IDLE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                KS_DEBOUNCE: begin
                    if (key_any && (col_pick == cand_q[1:0])) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_TARGET) begin
                            rel_d   = '0;
                            state_d = KS_PRESSED;
                        end
                    end else begin
                        deb_d   = '0;
                        state_d = KS_IDLE;
                    end
                end
                default: begin
                    rel_d = key_any ? '0 : rel_inc;
                    if (!key_any && (rel_inc == DEB_TARGET)) state_d = KS_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so rows move exactly at the tick edge.
    always_comb begin
        row_out_d   = (state_d == KS_IDLE) ? 4'b0000 : ~(4'b0001 << row_d);
        key_valid_d = (state_q == KS_DEBOUNCE) && (state_d == KS_PRESSED);
        key_down_d  = (state_d == KS_PRESSED);
        key_code_d  = key_valid_d ? cand_q : key_code_q;
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scanner: matrix model, tick-level reference, directed    |
// | key scenarios. Rev 1.0                                             |
// +--------------------------------------------------------------------+
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_N(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    function automatic logic [3:0] matrix(input logic [3:0] rows, input logic [15:0] keys);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (!rows[r] && keys[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic logic [3:0] rows_of(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return (r < 0) ? 4'b0000 : ~(one << r);
    endfunction

    function automatic int lowest_zero(input logic [3:0] v);
        for (int c = 0; c < 4; c++) if (!v[c]) return c;
        return -1;
    endfunction

    assign col_in = matrix(row_out, pressed);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_le(input string name, input int got, input int lim);
        total++;
        if (got > lim) begin
            bad++;
            $display("FAIL %s got=%0d expected<=%0d t=%0t", name, got, lim, $time);
        end
    endtask

    // Reference: m_row=-1 means all rows driven low; m_found = candidate being
    // confirmed; m_held = accepted key awaiting release.
    int         m_cnt   = 0;
    int         m_row   = -1;
    int         m_cand  = 0;
    int         m_count = 0;
    bit         m_found = 1'b0;
    bit         m_held  = 1'b0;
    bit         m_valid = 1'b0;
    logic [3:0] m_code  = 4'h0;
    logic [3:0] m_s1    = 4'hF;
    logic [3:0] m_s2    = 4'hF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_row <= -1; m_cand <= 0; m_count <= 0;
            m_found <= 1'b0; m_held <= 1'b0; m_valid <= 1'b0;
            m_code <= 4'h0; m_s1 <= 4'hF; m_s2 <= 4'hF;
        end else begin
            int row, cand, count, pc;
            bit found, held, valid, tick, any;
            logic [3:0] code, fresh;
            row = m_row; cand = m_cand; count = m_count;
            found = m_found; held = m_held; code = m_code;
            valid = 1'b0;
            fresh = matrix(rows_of(m_row), pressed);
            tick  = (m_cnt == DIV - 1);
            any   = (m_s2 != 4'hF);
            pc    = lowest_zero(m_s2);
            if (tick) begin
                if (held) begin
                    count = any ? 0 : count + 1;
                    if (count >= DEB) begin held = 1'b0; row = -1; count = 0; end
                end else if (found) begin
                    if (any && pc == cand % 4) begin
                        count = count + 1;
                        if (count >= DEB) begin
                            code = 4'(cand); valid = 1'b1; held = 1'b1;
                            found = 1'b0; count = 0;
                        end
                    end else begin
                        found = 1'b0; row = -1; count = 0;
                    end
                end else if (row < 0) begin
                    if (any) row = 0;
                end else if (any) begin
                    found = 1'b1; cand = row * 4 + pc; count = 1;
                end else if (row == 3) begin
                    row = -1;
                end else begin
                    row = row + 1;
                end
            end
            m_cnt <= tick ? 0 : m_cnt + 1;
            m_row <= row; m_cand <= cand; m_count <= count;
            m_found <= found; m_held <= held; m_valid <= valid; m_code <= code;
            m_s2 <= m_s1; m_s1 <= fresh;
        end
    end

    always @(negedge clk) begin
        chk("row_out", row_out, rows_of(m_row));
        chk("key_code", key_code, m_code);
        chk("key_valid", key_valid, m_valid);
        chk("key_down", key_down, m_held);
        if (key_valid) pulses++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_pulse(input string name, input int bound);
        int start, n;
        start = pulses;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (pulses == start && n < bound);
        chk({name, "_seen"}, pulses - start, 1);
        chk_le({name, "_latency"}, n, 31);
    endtask

    initial begin
        int p;
        // 1: reset, then idle for 100 ticks
        wait_clks(3);
        chk("rst_row_out", row_out, 4'b0000);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_down", key_down, 1'b0);
        chk("rst_key_code", key_code, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        wait_clks(100 * DIV);
        chk("idle_row_out", row_out, 4'b0000);
        chk("idle_pulses", pulses, 0);

        // 2: key row2/col1
        pressed[9] = 1'b1;
        p = pulses;
        wait_pulse("press9", 40);
        wait_clks(20);
        chk("press9_count", pulses - p, 1);
        chk("press9_code", key_code, 4'd9);
        chk("press9_down", key_down, 1'b1);

        // 4: short release does not end the press; full release does
        pressed[9] = 1'b0;
        wait_clks(2 * DIV);
        pressed[9] = 1'b1;
        wait_clks(20);
        chk("short_rel_down", key_down, 1'b1);
        chk("short_rel_nopulse", pulses - p, 1);
        pressed[9] = 1'b0;
        wait_clks(40);
        chk("release_down", key_down, 1'b0);
        chk("release_code", key_code, 4'd9);

        // 3: bounce toggling every tick never qualifies
        p = pulses;
        repeat (10) begin
            pressed[9] = ~pressed[9];
            wait_clks(DIV);
        end
        pressed = 16'h0000;
        wait_clks(40);
        chk("bounce_pulses", pulses - p, 0);

        // 5a: two columns in row 0, lowest column wins
        pressed[0] = 1'b1; pressed[2] = 1'b1;
        wait_pulse("row0", 40);
        chk("row0_code", key_code, 4'd0);
        pressed = 16'h0000;
        wait_clks(40);

        // 5b: rows 1 and 3 together, row 1 wins
        pressed[6] = 1'b1; pressed[13] = 1'b1;
        wait_pulse("rows13", 40);
        chk("rows13_code", key_code, 4'd6);
        pressed = 16'h0000;
        wait_clks(40);

        // 6: reset while pressed, key kept held
        pressed[9] = 1'b1;
        wait_pulse("pre_rst", 40);
        wait_clks(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_row_out", row_out, 4'b0000);
        chk("midrst_key_valid", key_valid, 1'b0);
        chk("midrst_key_down", key_down, 1'b0);
        chk("midrst_key_code", key_code, 4'h0);
        wait_clks(3);
        p = pulses;
        @(negedge clk) rst_n = 1'b1;
        wait_clks(3);
        chk("rst_release_nopulse", pulses - p, 0);
        wait_pulse("redetect", 40);
        wait_clks(20);
        chk("redetect_count", pulses - p, 1);
        chk("redetect_code", key_code, 4'd9);
        pressed = 16'h0000;
        wait_clks(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
